sap_1_fetch_controller: RTL and testbench

Program-counter, memory-address-register and T-state sequencer for the SAP-1 datapath. Sits directly upstream of the 16×8 SAP-1 program ROM: drives its 4-bit address and active-low chip enable, captures the returned word into the instruction register, and fetches operands for memory-reference instructions. Decoded opcode/operand and the one-hot T-state vector feed the downstream control and accumulator logic.

---
 rtl/sap_1_fetch_controller.sv | 122 ++++++++++++
 tb/tb_sap_1_fetch_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sap_1_fetch_controller.sv
// SAP-1 fetch controller: PC, MAR, IR, operand capture and one-hot T-state ring.
// Define SAP_1_FETCH_VAR_CYCLE_EN to shorten non-memref instructions to 4 clocks.
module sap_1_fetch_controller (
  input  logic       CLK,
  input  logic       CLRbar,
  input  logic [7:0] instruction_in,
  output logic [3:0] address_out,
  output logic       CEbar,
  output logic [3:0] pc_out,
  output logic [3:0] opcode_out,
  output logic [3:0] operand_out,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       out_en,
  output logic [5:0] t_state,
  output logic       halt
);

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // All-zero encoding doubles as the halted state.
  typedef enum logic [5:0] {
    T_HALT = 6'b000000,
    T1     = 6'b000001,
    T2     = 6'b000010,
    T3     = 6'b000100,
    T4     = 6'b001000,
    T5     = 6'b010000,
    T6     = 6'b100000
  } tstate_e;

  tstate_e    t_q, t_d;
  logic [3:0] pc_q, pc_d;
  logic [3:0] mar_q, mar_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] data_q, data_d;
  logic       halt_q, halt_d;

  logic       memref;
  logic       is_hlt;

  assign memref = (ir_q[7:4] == OP_LDA) || (ir_q[7:4] == OP_ADD) || (ir_q[7:4] == OP_SUB);
  assign is_hlt = (ir_q[7:4] == OP_HLT);

  always_ff @(posedge CLK or negedge CLRbar) begin
    if (!CLRbar) begin
      t_q    <= T1;
      pc_q   <= 4'h0;
      mar_q  <= 4'h0;
      ir_q   <= 8'h00;
      data_q <= 8'h00;
      halt_q <= 1'b0;
    end else begin
      t_q    <= t_d;
      pc_q   <= pc_d;
      mar_q  <= mar_d;
      ir_q   <= ir_d;
      data_q <= data_d;
      halt_q <= halt_d;
    end
  end

  always_comb begin
    t_d    = t_q;
    pc_d   = pc_q;
    mar_d  = mar_q;
    ir_d   = ir_q;
    data_d = data_q;
    halt_d = halt_q;
    case (t_q)
      T1: begin
        mar_d = pc_q;
        t_d   = T2;
      end
      T2: begin
        pc_d = pc_q + 4'd1;
        t_d  = T3;
      end
      T3: begin
        ir_d = instruction_in;
        t_d  = T4;
      end
      T4: begin
        t_d = T5;
        if (memref) begin
          mar_d = ir_q[3:0];
        end else if (is_hlt) begin
          halt_d = 1'b1;
          t_d    = T_HALT;
        end
`ifdef SAP_1_FETCH_VAR_CYCLE_EN
        else begin
          t_d = T1;
        end
`endif
      end
      T5: begin
        if (memref) data_d = instruction_in;
        t_d = T6;
      end
      T6:      t_d = T1;
      default: t_d = T_HALT;
    endcase
  end

  // ROM strobes depend only on registered state so a settling ROM word cannot glitch CEbar.
  assign CEbar       = ~((t_q == T3) || ((t_q == T5) && memref));
  assign out_en      = (t_q == T4) && (ir_q[7:4] == OP_OUT);
  assign data_valid  = (t_q == T6) && memref;
  assign address_out = mar_q;
  assign pc_out      = pc_q;
  assign opcode_out  = ir_q[7:4];
  assign operand_out = ir_q[3:0];
  assign data_out    = data_q;
  assign t_state     = t_q;
  assign halt        = halt_q;

endmodule

// File: tb/tb_sap_1_fetch_controller.sv
// Self-checking bench for sap_1_fetch_controller: cycle table plus directed multi-cycle sequences.
module tb_sap_1_fetch_controller;

  logic       CLK = 1'b0;
  logic       CLRbar = 1'b0;
  logic [7:0] instruction_in;
  logic [3:0] address_out, pc_out, opcode_out, operand_out;
  logic       CEbar, data_valid, out_en, halt;
  logic [7:0] data_out;
  logic [5:0] t_state;

  logic       use_rom = 1'b0;
  logic [7:0] drv = 8'h00;
  logic [7:0] rom [16];

  assign instruction_in = use_rom ? rom[address_out] : drv;

  always #5 CLK = ~CLK;

  sap_1_fetch_controller dut (
    .CLK(CLK), .CLRbar(CLRbar), .instruction_in(instruction_in),
    .address_out(address_out), .CEbar(CEbar), .pc_out(pc_out),
    .opcode_out(opcode_out), .operand_out(operand_out), .data_out(data_out),
    .data_valid(data_valid), .out_en(out_en), .t_state(t_state), .halt(halt)
  );

  typedef struct {
    logic [7:0] ins;
    logic [5:0] t;
    logic       ceb;
    logic [3:0] addr;
    logic [3:0] pc;
    logic [7:0] ir;
    logic       oe;
    logic       dv;
    logic [7:0] data;
    logic       hlt;
  } vec_t;

  vec_t vecs [$];
  int   checks = 0;
  int   passed = 0;

`ifdef SAP_1_FETCH_VAR_CYCLE_EN
  localparam int NONMEM_LEN = 4;
`else
  localparam int NONMEM_LEN = 6;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [7:0] ins, input logic [5:0] t, input logic ceb,
                              input logic [3:0] addr, input logic [3:0] pc, input logic [7:0] ir,
                              input logic oe, input logic dv, input logic [7:0] data,
                              input logic hlt);
    vec_t v;
    v.ins = ins; v.t = t; v.ceb = ceb; v.addr = addr; v.pc = pc;
    v.ir = ir; v.oe = oe; v.dv = dv; v.data = data; v.hlt = hlt;
    return v;
  endfunction

  task automatic apply_reset();
    @(negedge CLK);
    CLRbar = 1'b0;
    #2;
    CLRbar = 1'b1;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_t1(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (t_state == 6'b000001) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Fill ROM, reset, and measure clocks from one T1 to the next.
  task automatic measure(input logic [7:0] fill, output int len, output int oe_cnt,
                         output int dv_cnt, output logic [3:0] operand);
    for (int a = 0; a < 16; a++) rom[a] = fill;
    use_rom = 1'b1;
    apply_reset();
    #1;
    len = 0; oe_cnt = 0; dv_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_en) oe_cnt++;
      if (data_valid) dv_cnt++;
      step();
      len++;
      if (t_state == 6'b000001) break;
    end
    operand = operand_out;
  endtask

  initial begin
    bit ok;
    int len, oe_cnt, dv_cnt, bad;
    logic [3:0] opnd;

    // LDA 9 -> OUT 5 -> HLT, ROM word driven directly per cycle.
    //            ins    t       ceb addr  pc    ir     oe dv data   hlt
    vecs.push_back(mk(8'h00, 6'h01, 1, 4'h0, 4'h0, 8'h00, 0, 0, 8'h00, 0));
    vecs.push_back(mk(8'h00, 6'h02, 1, 4'h0, 4'h0, 8'h00, 0, 0, 8'h00, 0));
    vecs.push_back(mk(8'h09, 6'h04, 0, 4'h0, 4'h1, 8'h00, 0, 0, 8'h00, 0));
    vecs.push_back(mk(8'h00, 6'h08, 1, 4'h0, 4'h1, 8'h09, 0, 0, 8'h00, 0));
    vecs.push_back(mk(8'h1C, 6'h10, 0, 4'h9, 4'h1, 8'h09, 0, 0, 8'h00, 0));
    vecs.push_back(mk(8'h00, 6'h20, 1, 4'h9, 4'h1, 8'h09, 0, 1, 8'h1C, 0));
    vecs.push_back(mk(8'h00, 6'h01, 1, 4'h9, 4'h1, 8'h09, 0, 0, 8'h1C, 0));
    vecs.push_back(mk(8'h00, 6'h02, 1, 4'h1, 4'h1, 8'h09, 0, 0, 8'h1C, 0));
    vecs.push_back(mk(8'hE5, 6'h04, 0, 4'h1, 4'h2, 8'h09, 0, 0, 8'h1C, 0));
    vecs.push_back(mk(8'hAA, 6'h08, 1, 4'h1, 4'h2, 8'hE5, 1, 0, 8'h1C, 0));
`ifndef SAP_1_FETCH_VAR_CYCLE_EN
    vecs.push_back(mk(8'hAA, 6'h10, 1, 4'h1, 4'h2, 8'hE5, 0, 0, 8'h1C, 0));
    vecs.push_back(mk(8'hAA, 6'h20, 1, 4'h1, 4'h2, 8'hE5, 0, 0, 8'h1C, 0));
`endif
    vecs.push_back(mk(8'h00, 6'h01, 1, 4'h1, 4'h2, 8'hE5, 0, 0, 8'h1C, 0));
    vecs.push_back(mk(8'h00, 6'h02, 1, 4'h2, 4'h2, 8'hE5, 0, 0, 8'h1C, 0));
    vecs.push_back(mk(8'hF0, 6'h04, 0, 4'h2, 4'h3, 8'hE5, 0, 0, 8'h1C, 0));
    vecs.push_back(mk(8'h55, 6'h08, 1, 4'h2, 4'h3, 8'hF0, 0, 0, 8'h1C, 0));
    vecs.push_back(mk(8'h55, 6'h00, 1, 4'h2, 4'h3, 8'hF0, 0, 0, 8'h1C, 1));
    vecs.push_back(mk(8'h55, 6'h00, 1, 4'h2, 4'h3, 8'hF0, 0, 0, 8'h1C, 1));

    apply_reset();
    #1;
    foreach (vecs[i]) begin
      drv = vecs[i].ins;
      #1;
      chk($sformatf("v%0d t_state", i), 32'(t_state), 32'(vecs[i].t));
      chk($sformatf("v%0d CEbar", i), 32'(CEbar), 32'(vecs[i].ceb));
      chk($sformatf("v%0d address_out", i), 32'(address_out), 32'(vecs[i].addr));
      chk($sformatf("v%0d pc_out", i), 32'(pc_out), 32'(vecs[i].pc));
      chk($sformatf("v%0d ir", i), 32'({opcode_out, operand_out}), 32'(vecs[i].ir));
      chk($sformatf("v%0d out_en", i), 32'(out_en), 32'(vecs[i].oe));
      chk($sformatf("v%0d data_valid", i), 32'(data_valid), 32'(vecs[i].dv));
      chk($sformatf("v%0d data_out", i), 32'(data_out), 32'(vecs[i].data));
      chk($sformatf("v%0d halt", i), 32'(halt), 32'(vecs[i].hlt));
      step();
    end

    // Asynchronous reset mid-T3 after a completed LDA, with a held reset across an edge.
    for (int a = 0; a < 16; a++) rom[a] = 8'h00;
    rom[0] = 8'h09; rom[1] = 8'h09; rom[9] = 8'h1C;
    use_rom = 1'b1;
    apply_reset();
    #1;
    wait_t1(ok);
    chk("rst lda reached T1", 32'(ok), 32'd1);
    chk("rst lda data_out", 32'(data_out), 32'h1C);
    step(); step();
    chk("rst pre CEbar", 32'(CEbar), 32'd0);
    chk("rst pre t_state", 32'(t_state), 32'h04);
    #2;
    CLRbar = 1'b0;
    #1;
    chk("rst CEbar", 32'(CEbar), 32'd1);
    chk("rst t_state", 32'(t_state), 32'h01);
    chk("rst pc_out", 32'(pc_out), 32'd0);
    chk("rst address_out", 32'(address_out), 32'd0);
    chk("rst halt", 32'(halt), 32'd0);
    chk("rst data_out", 32'(data_out), 32'd0);
    chk("rst ir", 32'({opcode_out, operand_out}), 32'd0);
    @(posedge CLK);
    #1;
    chk("rst held ir", 32'({opcode_out, operand_out}), 32'd0);
    chk("rst held t_state", 32'(t_state), 32'h01);
    @(negedge CLK);
    CLRbar = 1'b1;

    // HLT after three OUT instructions; state must then freeze.
    for (int a = 0; a < 16; a++) rom[a] = 8'h00;
    rom[0] = 8'hE0; rom[1] = 8'hE0; rom[2] = 8'hE0; rom[3] = 8'hF0;
    apply_reset();
    #1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (halt) begin
        ok = 1'b1;
        break;
      end
    end
    chk("hlt reached", 32'(ok), 32'd1);
    chk("hlt t_state", 32'(t_state), 32'd0);
    chk("hlt pc_out", 32'(pc_out), 32'd4);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (CEbar !== 1'b1 || pc_out !== 4'd4 || t_state !== 6'd0 || out_en !== 1'b0 ||
          data_valid !== 1'b0 || halt !== 1'b1) bad++;
    end
    chk("hlt frozen cycles bad", 32'(bad), 32'd0);

    // PC wraps after 16 instructions; the 17th T1 addresses location 0.
    for (int a = 0; a < 16; a++) rom[a] = 8'h30;
    apply_reset();
    #1;
    bad = 0;
    for (int k = 0; k <= 16; k++) begin
      logic [3:0] kk;
      kk = 4'(k);
      if (pc_out !== kk) bad++;
      step();
      if (address_out !== kk) bad++;
      wait_t1(ok);
      if (!ok) begin
        bad++;
        break;
      end
    end
    chk("wrap mismatches", 32'(bad), 32'd0);
    chk("wrap final pc", 32'(pc_out), 32'd1);

    // Instruction lengths and strobes.
    measure(8'hE5, len, oe_cnt, dv_cnt, opnd);
    chk("out len", 32'(len), 32'(NONMEM_LEN));
    chk("out out_en count", 32'(oe_cnt), 32'd1);
    chk("out data_valid count", 32'(dv_cnt), 32'd0);
    chk("out operand", 32'(opnd), 32'd5);
    measure(8'h30, len, oe_cnt, dv_cnt, opnd);
    chk("nop len", 32'(len), 32'(NONMEM_LEN));
    chk("nop out_en count", 32'(oe_cnt), 32'd0);
    measure(8'h09, len, oe_cnt, dv_cnt, opnd);
    chk("lda len", 32'(len), 32'd6);
    chk("lda data_valid count", 32'(dv_cnt), 32'd1);
    chk("lda out_en count", 32'(oe_cnt), 32'd0);
    chk("lda data_out", 32'(data_out), 32'h09);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
